// File: rtl/mem_access_ctrl.sv
// Memory-stage sequencer in front of the 32-bit data memory. Runs one LW/SW/PUSH/POP
// per request through IDLE->ARM->ACCESS->DONE, owns the stack pointer, and rejects bad accesses.
module mem_access_ctrl #(
  parameter logic [31:0] DATA_END   = 32'd255,
  parameter logic [31:0] STACK_BASE = 32'd256,
  parameter logic [31:0] STACK_TOP  = 32'd511,
  parameter logic [31:0] PARK_ADDR  = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] addr_in,
  input  logic [31:0] wr_data,
  input  logic [31:0] mem_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        MemRd,
  output logic        MemWr,
  output logic [31:0] rd_data,
  output logic        done,
  output logic        busy,
  output logic        fault,
  output logic [31:0] sp
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ARM    = 2'd1,
    S_ACCESS = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam logic [1:0] OP_LW   = 2'b00;
  localparam logic [1:0] OP_SW   = 2'b01;
  localparam logic [1:0] OP_PUSH = 2'b10;
  localparam logic [1:0] OP_POP  = 2'b11;

  state_t      state_reg;
  logic [1:0]  op_reg;
  logic [31:0] data_reg;
  logic [31:0] target_reg;
  logic        req_fault_reg;
  logic [31:0] mem_addr_reg;
  logic [31:0] mem_wdata_reg;
  logic        mem_rd_reg;
  logic        mem_wr_reg;
  logic [31:0] rd_data_reg;
  logic        done_reg;
  logic        busy_reg;
  logic        fault_reg;
  logic [31:0] sp_reg;

  // Target address and rejection decision for the request currently on the inputs.
  logic [31:0] req_target_next;
  logic        req_fault_next;
  logic        req_is_read;
  logic        op_is_read;

  always_comb begin
    req_target_next = addr_in;
    req_fault_next  = (addr_in > DATA_END);
    case (op)
      OP_PUSH: begin
        req_target_next = sp_reg;
        req_fault_next  = (sp_reg < STACK_BASE);
      end
      OP_POP: begin
        req_target_next = sp_reg + 32'd1;
        req_fault_next  = (sp_reg >= STACK_TOP);
      end
      default: begin
        req_target_next = addr_in;
        req_fault_next  = (addr_in > DATA_END);
      end
    endcase
  end

  assign req_is_read = (op == OP_LW) || (op == OP_POP);
  assign op_is_read  = (op_reg == OP_LW) || (op_reg == OP_POP);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= S_IDLE;
      op_reg        <= OP_LW;
      data_reg      <= 32'd0;
      target_reg    <= PARK_ADDR;
      req_fault_reg <= 1'b0;
      mem_addr_reg  <= PARK_ADDR;
      mem_wdata_reg <= 32'd0;
      mem_rd_reg    <= 1'b0;
      mem_wr_reg    <= 1'b0;
      rd_data_reg   <= 32'd0;
      done_reg      <= 1'b0;
      busy_reg      <= 1'b0;
      fault_reg     <= 1'b0;
      sp_reg        <= STACK_TOP;
    end else begin
      case (state_reg)
        S_IDLE: begin
          done_reg   <= 1'b0;
          fault_reg  <= 1'b0;
          mem_wr_reg <= 1'b0;
          if (start) begin
            state_reg     <= S_ARM;
            busy_reg      <= 1'b1;
            op_reg        <= op;
            data_reg      <= wr_data;
            target_reg    <= req_target_next;
            req_fault_reg <= req_fault_next;
            // Read enable rises one cycle ahead of the address change.
            mem_rd_reg    <= req_is_read && !req_fault_next;
          end else begin
            mem_rd_reg <= 1'b0;
          end
        end

        S_ARM: begin
          state_reg <= S_ACCESS;
          if (!req_fault_reg) begin
            mem_addr_reg  <= target_reg;
            mem_wdata_reg <= data_reg;
            mem_rd_reg    <= op_is_read;
            mem_wr_reg    <= !op_is_read;
          end else begin
            mem_rd_reg <= 1'b0;
            mem_wr_reg <= 1'b0;
          end
        end

        S_ACCESS: begin
          state_reg    <= S_DONE;
          mem_addr_reg <= PARK_ADDR;
          mem_rd_reg   <= 1'b0;
          mem_wr_reg   <= 1'b0;
          done_reg     <= 1'b1;
          fault_reg    <= req_fault_reg;
          if (!req_fault_reg) begin
            if (op_is_read) begin
              rd_data_reg <= mem_rdata;
            end
            if (op_reg == OP_PUSH) begin
              sp_reg <= sp_reg - 32'd1;
            end else if (op_reg == OP_POP) begin
              sp_reg <= sp_reg + 32'd1;
            end
          end
        end

        S_DONE: begin
          state_reg  <= S_IDLE;
          done_reg   <= 1'b0;
          fault_reg  <= 1'b0;
          busy_reg   <= 1'b0;
          mem_rd_reg <= 1'b0;
          mem_wr_reg <= 1'b0;
        end

        default: begin
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

  // Strobes are gated by reset so a write in flight is never issued while reset is high.
  assign MemRd     = mem_rd_reg && !reset;
  assign MemWr     = mem_wr_reg && !reset;
  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;
  assign rd_data   = rd_data_reg;
  assign done      = done_reg;
  assign busy      = busy_reg;
  assign fault     = fault_reg;
  assign sp        = sp_reg;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: a table of single requests plus hand-written
// sequences for stack fill, start held high, and reset during a write.
module tb_mem_access_ctrl;

  localparam logic [1:0] OP_LW   = 2'b00;
  localparam logic [1:0] OP_SW   = 2'b01;
  localparam logic [1:0] OP_PUSH = 2'b10;
  localparam logic [1:0] OP_POP  = 2'b11;
  localparam logic [31:0] PARK   = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] addr_in;
  logic [31:0] wr_data;
  logic [31:0] mem_rdata;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        MemRd;
  logic        MemWr;
  logic [31:0] rd_data;
  logic        done;
  logic        busy;
  logic        fault;
  logic [31:0] sp;

  int tests = 0;
  int fails = 0;
  int wr_count = 0;

  always #5 clk = ~clk;

  mem_access_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .addr_in(addr_in),
    .wr_data(wr_data), .mem_rdata(mem_rdata), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .MemRd(MemRd), .MemWr(MemWr), .rd_data(rd_data),
    .done(done), .busy(busy), .fault(fault), .sp(sp)
  );

  // Data memory model: combinational read, write on the rising edge.
  logic [31:0] mem [0:1023];
  assign mem_rdata = mem[mem_addr[9:0]];
  always @(posedge clk) begin
    if (MemWr) begin
      mem[mem_addr[9:0]] <= mem_wdata;
      wr_count <= wr_count + 1;
    end
  end

  typedef struct {
    logic [1:0]  op;
    logic [31:0] addr;
    logic [31:0] data;
    logic        efault;
    logic [31:0] erd;
    logic [31:0] esp;
    int          ewr;
    logic [31:0] ewa;
    logic        eread;
  } vec_t;

  vec_t tbl [11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One request; checks latency, strobes, addresses, fault, rd_data and sp.
  task automatic run_req(input string nm, input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] d, input logic ef, input logic [31:0] erd,
                         input logic [31:0] esp, input int ewr, input logic [31:0] ewa,
                         input logic eread);
    int nwr = 0;
    int nrd = 0;
    int dcyc = 0;
    logic got_done = 1'b0;
    logic got_fault = 1'b0;
    logic [31:0] wa = 32'd0;
    logic [31:0] wd = 32'd0;
    logic [31:0] first_rd_addr = 32'd0;
    start = 1'b1; op = o; addr_in = a; wr_data = d;
    for (int c = 1; c <= 8 && !got_done; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (MemWr) begin nwr++; wa = mem_addr; wd = mem_wdata; end
      if (MemRd) begin
        if (nrd == 0) first_rd_addr = mem_addr;
        nrd++;
      end
      if (done) begin got_done = 1'b1; dcyc = c; got_fault = fault; end
    end
    chk({nm, " done_seen"}, 32'(got_done), 32'd1);
    chk({nm, " latency"}, 32'(dcyc), 32'd3);
    chk({nm, " fault"}, 32'(got_fault), 32'(ef));
    chk({nm, " wr_cycles"}, 32'(nwr), 32'(ewr));
    if (ewr == 1) begin
      chk({nm, " wr_addr"}, wa, ewa);
      chk({nm, " wr_data"}, wd, d);
    end
    chk({nm, " rd_asserted"}, 32'(nrd != 0), 32'(eread));
    if (eread) chk({nm, " rd_before_addr"}, first_rd_addr, PARK);
    chk({nm, " rd_data"}, rd_data, erd);
    chk({nm, " sp"}, sp, esp);
    $display("[TB] %s op=%0d addr=%0d data=%h -> fault=%0b rd_data=%h sp=%0d wr=%0d",
             nm, o, a, d, got_fault, rd_data, sp, nwr);
    @(negedge clk);
    chk({nm, " done_low_after"}, 32'(done), 32'd0);
    chk({nm, " busy_low_after"}, 32'(busy), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
    reset = 1'b1; start = 1'b0; op = OP_LW; addr_in = 32'd0; wr_data = 32'd0;

    //             op       addr    data          flt erd            esp   wr wa     rd
    tbl[0]  = '{OP_POP,  32'd0,   32'd0,         1, 32'd0,         511, 0, 32'd0,   0};
    tbl[1]  = '{OP_SW,   32'd10,  32'hDEAD_BEEF, 0, 32'd0,         511, 1, 32'd10,  0};
    tbl[2]  = '{OP_LW,   32'd10,  32'd0,         0, 32'hDEAD_BEEF, 511, 0, 32'd0,   1};
    tbl[3]  = '{OP_PUSH, 32'd0,   32'h11,        0, 32'hDEAD_BEEF, 510, 1, 32'd511, 0};
    tbl[4]  = '{OP_PUSH, 32'd0,   32'h22,        0, 32'hDEAD_BEEF, 509, 1, 32'd510, 0};
    tbl[5]  = '{OP_POP,  32'd0,   32'd0,         0, 32'h22,        510, 0, 32'd0,   1};
    tbl[6]  = '{OP_POP,  32'd0,   32'd0,         0, 32'h11,        511, 0, 32'd0,   1};
    tbl[7]  = '{OP_LW,   32'd256, 32'd0,         1, 32'h11,        511, 0, 32'd0,   0};
    tbl[8]  = '{OP_SW,   32'd255, 32'hCAFE_0001, 0, 32'h11,        511, 1, 32'd255, 0};
    tbl[9]  = '{OP_LW,   32'd255, 32'd0,         0, 32'hCAFE_0001, 511, 0, 32'd0,   1};
    tbl[10] = '{OP_SW,   32'd300, 32'h5555_AAAA, 1, 32'hCAFE_0001, 511, 0, 32'd0,   0};

    repeat (2) @(negedge clk);
    chk("rst mem_addr", mem_addr, PARK);
    chk("rst mem_wdata", mem_wdata, 32'd0);
    chk("rst MemRd", 32'(MemRd), 32'd0);
    chk("rst MemWr", 32'(MemWr), 32'd0);
    chk("rst rd_data", rd_data, 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst fault", 32'(fault), 32'd0);
    chk("rst sp", sp, 32'd511);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 11; i++) begin
      run_req($sformatf("vec%0d", i), tbl[i].op, tbl[i].addr, tbl[i].data, tbl[i].efault,
              tbl[i].erd, tbl[i].esp, tbl[i].ewr, tbl[i].ewa, tbl[i].eread);
    end

    // Fill the whole stack, then overflow.
    for (int i = 0; i < 256; i++) begin
      run_req($sformatf("push%0d", i), OP_PUSH, 32'd0, 32'h1000 + 32'(i), 1'b0,
              32'hCAFE_0001, 32'(510 - i), 1, 32'(511 - i), 1'b0);
    end
    run_req("push_full", OP_PUSH, 32'd0, 32'h9999, 1'b1, 32'hCAFE_0001, 32'd255, 0, 32'd0, 1'b0);
    run_req("lw_256", OP_LW, 32'd256, 32'd0, 1'b1, 32'hCAFE_0001, 32'd255, 0, 32'd0, 1'b0);
    run_req("pop_top", OP_POP, 32'd0, 32'd0, 1'b0, 32'h1000 + 32'd255, 32'd256, 0, 32'd0, 1'b1);

    // start held high: one accept every 4 cycles, busy 1,1,1,0.
    start = 1'b1; op = OP_LW; addr_in = 32'd10; wr_data = 32'd0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      chk($sformatf("hold busy c%0d", k), 32'(busy), 32'((k % 4) != 0));
      chk($sformatf("hold done c%0d", k), 32'(done), 32'((k % 4) == 3));
    end
    start = 1'b0;
    $display("[TB] start-held sequence: 12 cycles checked");
    @(negedge clk);
    chk("hold idle busy", 32'(busy), 32'd0);

    // Reset during ACCESS of a PUSH: write must not be issued.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    begin
      int wr_before;
      wr_before = wr_count;
      start = 1'b1; op = OP_PUSH; wr_data = 32'h7777;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      chk("rstacc MemWr_pre", 32'(MemWr), 32'd1);
      reset = 1'b1;
      #1;
      chk("rstacc MemWr_gated", 32'(MemWr), 32'd0);
      @(negedge clk);
      chk("rstacc busy", 32'(busy), 32'd0);
      chk("rstacc done", 32'(done), 32'd0);
      chk("rstacc sp", sp, 32'd511);
      chk("rstacc mem_addr", mem_addr, PARK);
      chk("rstacc writes", 32'(wr_count - wr_before), 32'd0);
      reset = 1'b0;
      @(negedge clk);
      chk("rstacc idle busy", 32'(busy), 32'd0);
      chk("rstacc MemWr_after", 32'(MemWr), 32'd0);
      $display("[TB] reset during PUSH access: sp=%0d busy=%0b", sp, busy);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
